// File: rtl/alu_cmd_sequencer.sv
// Registered command front-end for the combinational ALU: result and flags are visible 2 cycles after acceptance.
// One command in flight; cmd_ready is low until the held result is taken by res_valid && res_ready.
module alu_cmd_sequencer #(
  parameter int               WIDTH    = 8,
  parameter int               SEL_W    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SEL_W-1:0] cmd_op,
  input  logic             cmd_use_acc,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_wb,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [4:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [4:0]       flags,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t state;
  logic   wb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wb        <= 1'b0;
      acc       <= ACC_INIT;
      flags     <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // acc already includes the previous command's write-back here
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_op;
            wb      <= cmd_wb;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_out;
          flags     <= alu_flags;
          if (wb) acc <= alu_out;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

endmodule
